// File: rtl/mem_arbiter_if.sv
// Pipeline/memory-side signal bundle for mem_arbiter; master = pipeline stages plus RAM, slave = arbiter.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, stallreq_if_o, stallreq_mem_o,
               mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, stallreq_if_o, stallreq_mem_o,
               mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one wait-stated RAM bus between fetch (IF) and data (DM) ports; ties go to DM unless ARB_ROUND_ROBIN_EN.
// Latency: bus enabled WAIT_CYCLES+1 cycles after grant, ack WAIT_CYCLES+2 after; one access per WAIT_CYCLES+3.
// Backpressure: stallreq_*_o stays high while a port's request is waiting for its ack.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        grant;
    logic [31:0] rdata_q;
    req_t        req_q;
    logic        ce_q;
    logic        we_q;
    logic        if_ack_q;
    logic        dm_ack_q;
    logic        pick_dm;

    // grant doubles as the last-granted port for tie breaking
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_dm = bus.dm_req_i & (~bus.if_req_i | ~grant);
`else
        pick_dm = bus.dm_req_i;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            grant    <= 1'b0;
            rdata_q  <= 32'd0;
            req_q    <= '0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req_i | bus.dm_req_i) begin
                        grant <= pick_dm;
                        cnt   <= 4'(WAIT_CYCLES);
                        ce_q  <= 1'b1;
                        state <= ACCESS;
                        if (pick_dm) begin
                            req_q.we    <= bus.dm_we_i;
                            req_q.sel   <= bus.dm_sel_i;
                            req_q.addr  <= bus.dm_addr_i;
                            req_q.wdata <= bus.dm_wdata_i;
                            we_q        <= bus.dm_we_i;
                        end else begin
                            req_q.we   <= 1'b0;
                            req_q.sel  <= 4'hF;
                            req_q.addr <= bus.if_addr_i;
                            we_q       <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= DONE;
                        ce_q     <= 1'b0;
                        we_q     <= 1'b0;
                        if_ack_q <= ~grant;
                        dm_ack_q <= grant;
                        if (!req_q.we) begin
                            rdata_q <= bus.mem_rdata_i;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_ce_o       = ce_q;
    assign bus.mem_we_o       = we_q;
    assign bus.mem_sel_o      = req_q.sel;
    assign bus.mem_addr_o     = req_q.addr;
    assign bus.mem_wdata_o    = req_q.wdata;
    assign bus.if_ack_o       = if_ack_q;
    assign bus.dm_ack_o       = dm_ack_q;
    assign bus.if_rdata_o     = rdata_q;
    assign bus.dm_rdata_o     = rdata_q;
    assign bus.stallreq_if_o  = bus.if_req_i & ~if_ack_q;
    assign bus.stallreq_mem_o = bus.dm_req_i & ~dm_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: five instances with different wait states, directed vectors and a random run against a timeline model.
module tb_mem_arbiter;
    localparam int N = 5;
    localparam logic [N-1:0][3:0] WCP = {4'd15, 4'd3, 4'd2, 4'd1, 4'd0};
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int RANDCYC = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_v;
    logic        if_req [N];
    logic [31:0] if_addr [N];
    logic        dm_req [N];
    logic        dm_we [N];
    logic [3:0]  dm_sel [N];
    logic [31:0] dm_addr [N];
    logic [31:0] dm_wdata [N];
    logic        o_ce [N];
    logic        o_we [N];
    logic [3:0]  o_sel [N];
    logic [31:0] o_addr [N];
    logic [31:0] o_wd [N];
    logic        o_if_ack [N];
    logic        o_dm_ack [N];
    logic [31:0] o_if_rd [N];
    logic [31:0] o_dm_rd [N];
    logic        o_sif [N];
    logic        o_sdm [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h2401_0001;
            32'h0000_0040: return 32'h0000_FFFF;
            default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_arbiter_if bus ();
        mem_arbiter #(.WAIT_CYCLES(int'(WCP[g]))) u_dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus)
        );
        assign bus.if_req_i    = if_req[g];
        assign bus.if_addr_i   = if_addr[g];
        assign bus.dm_req_i    = dm_req[g];
        assign bus.dm_we_i     = dm_we[g];
        assign bus.dm_sel_i    = dm_sel[g];
        assign bus.dm_addr_i   = dm_addr[g];
        assign bus.dm_wdata_i  = dm_wdata[g];
        assign bus.mem_rdata_i = memfn(bus.mem_addr_o);
        assign o_ce[g]     = bus.mem_ce_o;
        assign o_we[g]     = bus.mem_we_o;
        assign o_sel[g]    = bus.mem_sel_o;
        assign o_addr[g]   = bus.mem_addr_o;
        assign o_wd[g]     = bus.mem_wdata_o;
        assign o_if_ack[g] = bus.if_ack_o;
        assign o_dm_ack[g] = bus.dm_ack_o;
        assign o_if_rd[g]  = bus.if_rdata_o;
        assign o_dm_rd[g]  = bus.dm_rdata_o;
        assign o_sif[g]    = bus.stallreq_if_o;
        assign o_sdm[g]    = bus.stallreq_mem_o;
    end

    function automatic int wc(input int k);
        return int'(WCP[k]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            if_req[k] = 1'b0; if_addr[k] = 32'd0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_sel[k] = 4'd0;
            dm_addr[k] = 32'd0; dm_wdata[k] = 32'd0;
        end
    endtask

    typedef struct {
        int          inst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dma;
        logic [31:0] wd;
        logic        e_ce;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_wd;
        logic        e_ifack;
        logic        e_dmack;
        logic [31:0] e_rd;
        logic        e_sif;
        logic        e_sdm;
    } vec_t;

    vec_t tv[$];

    task automatic add(input int inst, input logic ifr, input logic [31:0] ifa,
                       input logic dmr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dma, input logic [31:0] wd,
                       input logic e_ce, input logic e_we, input logic [31:0] e_addr,
                       input logic [3:0] e_sel, input logic [31:0] e_wd,
                       input logic e_ifack, input logic e_dmack, input logic [31:0] e_rd,
                       input logic e_sif, input logic e_sdm);
        vec_t v;
        v = '{inst, ifr, ifa, dmr, we, sel, dma, wd, e_ce, e_we, e_addr, e_sel, e_wd,
              e_ifack, e_dmack, e_rd, e_sif, e_sdm};
        tv.push_back(v);
    endtask

    // timeline model state for the random run
    int          m_idle_at [N];
    int          m_st [N];
    bit          m_act [N];
    bit          m_win [N];
    bit          m_last [N];
    bit          m_we [N];
    logic [3:0]  m_sel [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wd [N];
    logic [31:0] m_rd [N];
    bit          p_if [N];
    bit          p_dm [N];

    task automatic model_cycle(input int k);
        int  w;
        bit  in_acc, ack, tie;
        w      = wc(k);
        in_acc = m_act[k] && cyc >= m_st[k] + 1 && cyc <= m_st[k] + w + 1;
        ack    = m_act[k] && cyc == m_st[k] + w + 2;
        chk($sformatf("rnd_ce[%0d]", k), 32'(o_ce[k]), 32'(in_acc));
        chk($sformatf("rnd_we[%0d]", k), 32'(o_we[k]), 32'(in_acc && m_we[k]));
        chk($sformatf("rnd_addr[%0d]", k), o_addr[k], m_addr[k]);
        chk($sformatf("rnd_sel[%0d]", k), 32'(o_sel[k]), 32'(m_sel[k]));
        chk($sformatf("rnd_wdata[%0d]", k), o_wd[k], m_wd[k]);
        chk($sformatf("rnd_if_ack[%0d]", k), 32'(o_if_ack[k]), 32'(ack && !m_win[k]));
        chk($sformatf("rnd_dm_ack[%0d]", k), 32'(o_dm_ack[k]), 32'(ack && m_win[k]));
        chk($sformatf("rnd_stall_if[%0d]", k), 32'(o_sif[k]), 32'(p_if[k] && !(ack && !m_win[k])));
        chk($sformatf("rnd_stall_mem[%0d]", k), 32'(o_sdm[k]), 32'(p_dm[k] && !(ack && m_win[k])));
        if (ack && m_win[k]) chk($sformatf("rnd_dm_rdata[%0d]", k), o_dm_rd[k], m_rd[k]);
        if (ack && !m_win[k]) chk($sformatf("rnd_if_rdata[%0d]", k), o_if_rd[k], m_rd[k]);
        if (ack) begin
            if (m_win[k]) p_dm[k] = 1'b0;
            else          p_if[k] = 1'b0;
        end
        if (cyc >= m_idle_at[k] && (if_req[k] || dm_req[k])) begin
            tie = if_req[k] && dm_req[k];
            m_win[k]     = (RR && tie) ? !m_last[k] : dm_req[k];
            m_last[k]    = m_win[k];
            m_st[k]      = cyc;
            m_idle_at[k] = cyc + w + 3;
            m_act[k]     = 1'b1;
            if (m_win[k]) begin
                m_we[k]   = dm_we[k];
                m_sel[k]  = dm_sel[k];
                m_addr[k] = dm_addr[k];
                m_wd[k]   = dm_wdata[k];
                if (!dm_we[k]) m_rd[k] = memfn(dm_addr[k]);
            end else begin
                m_we[k]   = 1'b0;
                m_sel[k]  = 4'hF;
                m_addr[k] = if_addr[k];
                m_rd[k]   = memfn(if_addr[k]);
            end
        end
    endtask

    initial begin
        int if_at, dm_at, stall_cnt;
        bit e_dm, e_if;

        // single fetch on WAIT=2 instance, then read / write / zero-sel write on WAIT=0 instance
        add(2, 1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,   4'h0, 0, 0, 0, 0, 1, 0);
        add(2, 1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 1, 0);
        add(2, 1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 1, 0);
        add(2, 1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 1, 0);
        add(2, 1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0, 32'h100, 4'hF, 0, 1, 0, 32'h2401_0001, 0, 0);
        add(2, 0, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, 32'h0,  4'h0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 4'hF, 32'h40, 0, 1, 0, 32'h40, 4'hF, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, 32'h40, 4'hF, 0, 0, 1, 32'h0000_FFFF, 0, 0);
        add(0, 0, 0, 1, 1, 4'h3, 32'h20, 32'hDEAD_BEEF, 0, 0, 32'h40, 4'hF, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 4'h3, 32'h20, 32'hDEAD_BEEF, 1, 1, 32'h20, 4'h3, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 4'h3, 32'h20, 32'hDEAD_BEEF, 0, 0, 32'h20, 4'h3, 32'hDEAD_BEEF, 0, 1, 32'h0000_FFFF, 0, 0);
        add(0, 0, 0, 1, 1, 4'h0, 32'h24, 32'h1, 0, 0, 32'h20, 4'h3, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 4'h0, 32'h24, 32'h1, 1, 1, 32'h24, 4'h0, 32'h1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 4'h0, 32'h24, 32'h1, 0, 0, 32'h24, 4'h0, 32'h1, 0, 1, 32'h0000_FFFF, 0, 0);
        add(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h24, 4'h0, 32'h1, 0, 0, 0, 0, 0);

        idle_all();
        rst_v = '1;
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_ce[%0d]", k), 32'(o_ce[k]), 0);
            chk($sformatf("rst_we[%0d]", k), 32'(o_we[k]), 0);
            chk($sformatf("rst_addr[%0d]", k), o_addr[k], 0);
            chk($sformatf("rst_sel[%0d]", k), 32'(o_sel[k]), 0);
            chk($sformatf("rst_wdata[%0d]", k), o_wd[k], 0);
            chk($sformatf("rst_if_ack[%0d]", k), 32'(o_if_ack[k]), 0);
            chk($sformatf("rst_dm_ack[%0d]", k), 32'(o_dm_ack[k]), 0);
            chk($sformatf("rst_if_rdata[%0d]", k), o_if_rd[k], 0);
            chk($sformatf("rst_dm_rdata[%0d]", k), o_dm_rd[k], 0);
        end
        rst_v = '0;
        tick();

        foreach (tv[i]) begin
            int k;
            k = tv[i].inst;
            if_req[k] = tv[i].ifr;  if_addr[k] = tv[i].ifa;
            dm_req[k] = tv[i].dmr;  dm_we[k] = tv[i].we;  dm_sel[k] = tv[i].sel;
            dm_addr[k] = tv[i].dma; dm_wdata[k] = tv[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d_ce", i), 32'(o_ce[k]), 32'(tv[i].e_ce));
            chk($sformatf("vec%0d_we", i), 32'(o_we[k]), 32'(tv[i].e_we));
            chk($sformatf("vec%0d_addr", i), o_addr[k], tv[i].e_addr);
            chk($sformatf("vec%0d_sel", i), 32'(o_sel[k]), 32'(tv[i].e_sel));
            chk($sformatf("vec%0d_wdata", i), o_wd[k], tv[i].e_wd);
            chk($sformatf("vec%0d_if_ack", i), 32'(o_if_ack[k]), 32'(tv[i].e_ifack));
            chk($sformatf("vec%0d_dm_ack", i), 32'(o_dm_ack[k]), 32'(tv[i].e_dmack));
            chk($sformatf("vec%0d_stall_if", i), 32'(o_sif[k]), 32'(tv[i].e_sif));
            chk($sformatf("vec%0d_stall_mem", i), 32'(o_sdm[k]), 32'(tv[i].e_sdm));
            if (tv[i].e_ifack) chk($sformatf("vec%0d_if_rdata", i), o_if_rd[k], tv[i].e_rd);
            if (tv[i].e_dmack) chk($sformatf("vec%0d_dm_rdata", i), o_dm_rd[k], tv[i].e_rd);
            tick();
        end
        idle_all();
        tick();

        // simultaneous requests on WAIT=1; each port drops its request after its ack
        if_at = -1; dm_at = -1; stall_cnt = 0;
        if_req[1] = 1'b1; if_addr[1] = 32'h200;
        dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_sel[1] = 4'hF; dm_addr[1] = 32'h300;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_dm_ack[1] && dm_at < 0) dm_at = c;
            if (o_if_ack[1] && if_at < 0) if_at = c;
            if (c < 7 && o_sif[1]) stall_cnt++;
            tick();
            if (dm_at >= 0) dm_req[1] = 1'b0;
            if (if_at >= 0) if_req[1] = 1'b0;
        end
        chk("tie_dm_ack_cycle", 32'(dm_at), 32'd3);
        chk("tie_if_ack_cycle", 32'(if_at), 32'd7);
        chk("tie_if_stall_cycles", 32'(stall_cnt), 32'd7);
        tick();

        // both ports held high continuously
        if_req[1] = 1'b1; dm_req[1] = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            e_dm = (c % 4 == 3) && (!RR || ((c / 4) % 2 == 0));
            e_if = (c % 4 == 3) && RR && ((c / 4) % 2 == 1);
            chk($sformatf("held_dm_ack_c%0d", c), 32'(o_dm_ack[1]), 32'(e_dm));
            chk($sformatf("held_if_ack_c%0d", c), 32'(o_if_ack[1]), 32'(e_if));
            chk($sformatf("held_stall_if_c%0d", c), 32'(o_sif[1]), 32'(!e_if));
            tick();
        end
        idle_all();
        tick();
        tick();

        // reset in the second ACCESS cycle of a WAIT=3 read, request held throughout
        dm_req[3] = 1'b1; dm_we[3] = 1'b0; dm_sel[3] = 4'hF; dm_addr[3] = 32'h1000;
        for (int c = 0; c < 11; c++) begin
            rst_v[3]  = (c == 2);
            dm_req[3] = (c <= 8);
            @(negedge clk);
            chk($sformatf("rstmid_ce_c%0d", c), 32'(o_ce[3]), 32'((c >= 1 && c <= 2) || (c >= 4 && c <= 7)));
            chk($sformatf("rstmid_ack_c%0d", c), 32'(o_dm_ack[3]), 32'(c == 8));
            chk($sformatf("rstmid_stall_c%0d", c), 32'(o_sdm[3]), 32'(c < 8));
            tick();
        end
        rst_v[3] = 1'b0;

        // maximum wait states
        dm_we[4] = 1'b0; dm_sel[4] = 4'hF; dm_addr[4] = 32'h40;
        for (int c = 0; c < 20; c++) begin
            dm_req[4] = (c <= 17);
            @(negedge clk);
            chk($sformatf("w15_ce_c%0d", c), 32'(o_ce[4]), 32'(c >= 1 && c <= 16));
            chk($sformatf("w15_ack_c%0d", c), 32'(o_dm_ack[4]), 32'(c == 17));
            if (c == 17) chk("w15_rdata", o_dm_rd[4], 32'h0000_FFFF);
            tick();
        end

        // random traffic on all instances against the timeline model
        idle_all();
        rst_v = '1;
        tick();
        rst_v = '0;
        for (int k = 0; k < N; k++) begin
            m_idle_at[k] = cyc; m_st[k] = 0; m_act[k] = 0; m_win[k] = 0; m_last[k] = 0;
            m_we[k] = 0; m_sel[k] = 4'h0; m_addr[k] = 0; m_wd[k] = 0; m_rd[k] = 0;
            p_if[k] = 0; p_dm[k] = 0;
        end
        for (int n = 0; n < RANDCYC; n++) begin
            for (int k = 0; k < N; k++) begin
                if (!p_if[k] && $urandom_range(0, 3) == 0) begin
                    p_if[k] = 1'b1;
                    if_addr[k] = $urandom & 32'hFFFF_FFFC;
                end
                if (!p_dm[k] && $urandom_range(0, 3) == 0) begin
                    p_dm[k] = 1'b1;
                    dm_we[k]    = 1'($urandom_range(0, 1));
                    dm_sel[k]   = 4'($urandom_range(0, 15));
                    dm_addr[k]  = $urandom & 32'hFFFF_FFFC;
                    dm_wdata[k] = $urandom;
                end
                if_req[k] = p_if[k];
                dm_req[k] = p_dm[k];
            end
            @(negedge clk);
            for (int k = 0; k < N; k++) model_cycle(k);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
